// File: rtl/variable_node_message_accumulator_pkg.sv
// Shared types and helpers for the variable-node message path.
// State encoding plus a width-generic signed saturating clamp.
package variable_node_message_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Clamp arithmetic is done at this width so one
    // function serves any accumulator/output width pair.
    localparam int SAT_CALC_WIDTH = 64;

    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = sat_hi(w);
        lo = sat_lo(w);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/variable_node_message_accumulator_if.sv
// Beat-in / result-out handshake bundle of the accumulator.
// slave: accumulator side; master: producer + penalty-stage side.
interface variable_node_message_accumulator_if #(
    parameter int TAG_WIDTH  = 32,
    parameter int DATA_WIDTH = 18,
    parameter int DEG_WIDTH  = 4
);
    logic                         valid_in;
    logic                         ready_out;
    logic [TAG_WIDTH-1:0]         tag_in;
    logic [DEG_WIDTH-1:0]         degree;
    logic signed [DATA_WIDTH-1:0] channelTerm;
    logic signed [DATA_WIDTH-1:0] msg_in;
    logic                         ready_in;
    logic                         valid_out;
    logic [TAG_WIDTH-1:0]         tag_out;
    logic signed [DATA_WIDTH-1:0] prePenalty;

    modport slave (
        input  valid_in, tag_in, degree, channelTerm, msg_in, ready_in,
        output ready_out, valid_out, tag_out, prePenalty
    );

    modport master (
        output valid_in, tag_in, degree, channelTerm, msg_in, ready_in,
        input  ready_out, valid_out, tag_out, prePenalty
    );
endinterface

// File: rtl/variable_node_message_accumulator_fixed_point_saturate.sv
// Combinational signed clamp from IN_WIDTH down to OUT_WIDTH.
// Ports: din (IN_WIDTH signed), dout (OUT_WIDTH signed, saturated).
module fixed_point_saturate
    import variable_node_message_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 18
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);
    logic signed [SAT_CALC_WIDTH-1:0] wide;
    logic signed [SAT_CALC_WIDTH-1:0] clamped;

    assign wide    = SAT_CALC_WIDTH'(din);
    assign clamped = sat_clamp(wide, OUT_WIDTH);
    assign dout    = OUT_WIDTH'(clamped);
endmodule

// File: rtl/variable_node_message_accumulator.sv
// Serially sums DEGREE messages plus channel term; emits one saturated word.
// Ports: clk, reset (sync high), bus (slave handshake), busy, err_degree.
module variable_node_message_accumulator
    import variable_node_message_accumulator_pkg::*;
#(
    parameter int TAG_WIDTH      = 32,
    parameter int DATA_WIDTH     = 18,
    parameter int FRACTION_WIDTH = 10,
    parameter int MAX_DEGREE     = 8,
    parameter int DEG_WIDTH      = 4
) (
    input  logic clk,
    input  logic reset,
    variable_node_message_accumulator_if.slave bus,
    output logic busy,
    output logic err_degree
);
    // One guard bit beyond DEG_WIDTH covers MAX_DEGREE+1 terms.
    localparam int ACC_WIDTH = DATA_WIDTH + DEG_WIDTH + 1;

    state_t                      state;
    state_t                      state_nxt;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic [DEG_WIDTH-1:0]        deg_q;
    logic [DEG_WIDTH-1:0]        count;
    logic [DEG_WIDTH-1:0]        deg_eff;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] msg_ext;
    logic signed [ACC_WIDTH-1:0] ch_ext;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic                        beat;
    logic                        deg_legal;
    logic                        last_beat;

    assign beat      = bus.valid_in & bus.ready_out;
    assign msg_ext   = ACC_WIDTH'(bus.msg_in);
    assign ch_ext    = ACC_WIDTH'(bus.channelTerm);
    assign deg_legal = (bus.degree != '0) &&
                       (bus.degree <= DEG_WIDTH'(MAX_DEGREE));
    // Illegal degrees collapse to a single-message group.
    assign deg_eff   = deg_legal ? bus.degree : DEG_WIDTH'(1);
    assign last_beat = (DEG_WIDTH'(count + 1'b1) == deg_q);

    fixed_point_saturate #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_sat (
        .din  (acc),
        .dout (sat_val)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (beat)
                       state_nxt = (deg_eff == DEG_WIDTH'(1)) ? SAT : ACCUM;
            ACCUM: if (beat && last_beat) state_nxt = SAT;
            SAT:   state_nxt = HOLD;
            HOLD:  if (bus.ready_in) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_out = (state == IDLE) || (state == ACCUM);
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            count          <= '0;
            tag_q          <= '0;
            deg_q          <= '0;
            err_degree     <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.tag_out    <= '0;
            bus.prePenalty <= '0;
        end else begin
            unique case (state)
                IDLE: if (beat) begin
                    acc   <= ch_ext + msg_ext;
                    tag_q <= bus.tag_in;
                    deg_q <= deg_eff;
                    count <= DEG_WIDTH'(1);
                    if (!deg_legal) err_degree <= 1'b1;
                end
                ACCUM: if (beat) begin
                    acc   <= acc + msg_ext;
                    count <= count + 1'b1;
                end
                SAT: begin
                    bus.prePenalty <= sat_val;
                    bus.tag_out    <= tag_q;
                    bus.valid_out  <= 1'b1;
                end
                HOLD: if (bus.ready_in) bus.valid_out <= 1'b0;
            endcase
        end
    end
endmodule
